// File: rtl/sr_div_pkg.sv
// Shared definitions for the sequential divider: MDU funct3 encodings,
// divider FSM states and the special-case result constants.
package sr_div_pkg;

  localparam int unsigned DIV_XLEN = 32;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [DIV_XLEN-1:0] DIV_ALL_ONES = {DIV_XLEN{1'b1}};
  localparam logic [DIV_XLEN-1:0] DIV_INT_MIN  = {1'b1, {(DIV_XLEN-1){1'b0}}};

endpackage

// File: rtl/sr_div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per clock,
// with divide-by-zero and signed overflow resolved in the accept cycle.
module sr_div
  import sr_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [2:0]       oper,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] cond_neg(input logic en, input logic [WIDTH-1:0] v);
    return en ? -v : v;
  endfunction

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             is_rem_q, is_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic             signed_op, a_neg, b_neg, accept;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   rem_sh, trial;
  logic             fits;
  logic [WIDTH-1:0] step_rem, step_quo;

  assign accept    = start && !busy_q && oper[2];
  assign signed_op = !oper[0];
  assign a_s       = srcA;
  assign b_s       = srcB;
  assign a_neg     = signed_op && (a_s < 0);
  assign b_neg     = signed_op && (b_s < 0);
  assign mag_a     = cond_neg(a_neg, srcA);
  assign mag_b     = cond_neg(b_neg, srcB);

  // Restoring step: shift the dividend MSB into the partial remainder and keep the difference only if it fits.
  assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, dvs_q};
  assign fits     = (rem_sh >= {1'b0, dvs_q});
  assign step_rem = fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign step_quo = {quo_q[WIDTH-2:0], fits};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    case (state_q)
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (count_q == CNT_LAST) begin
          result_d = is_rem_q ? cond_neg(neg_rem_q, step_rem) : cond_neg(neg_quo_q, step_quo);
          state_d  = DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      count_d   = '0;
      rem_d     = '0;
      quo_d     = mag_a;
      dvs_d     = mag_b;
      is_rem_d  = oper[1];
      neg_quo_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      if (srcB == '0) begin
        result_d = oper[1] ? srcA : ALL_ONES;
        state_d  = DONE;
      end else if (signed_op && srcA == INT_MIN && srcB == ALL_ONES) begin
        result_d = oper[1] ? '0 : INT_MIN;
        state_d  = DONE;
      end else begin
        state_d = CALC;
      end
    end

    busy_d  = (state_d == CALC);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
    end
  end

  assign busy   = busy_q;
  assign valid  = valid_q;
  assign result = result_q;

endmodule

// File: tb/tb_sr_div.sv
// Scoreboard bench for sr_div: stimulus queues expected results with their
// accept cycle, a negedge monitor checks result and latency on every valid.
module tb_sr_div;
  import sr_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] srcA, srcB;
  logic [2:0]  oper;
  logic        busy, valid;
  logic [31:0] result;

  sr_div #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .srcA(srcA), .srcB(srcB),
    .oper(oper), .busy(busy), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got result 0x%08h, expected no valid", result);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_result"}, result, mon_e.res);
        check({mon_e.name, "_latency"}, 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
    end
  end

  // Drives one request; lat is the number of edges from accept to the result-write edge.
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lat,
                       input bit at_negedge_now);
    if (!at_negedge_now) @(negedge clk);
    oper  = op;
    srcA  = a;
    srcB  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back('{res, cyc, lat, name});
    srcA  = ~a;
    srcB  = b + 32'd1;
    oper  = MDU_MUL;
    @(negedge clk);
    check({name, "_busy"}, {31'b0, busy}, (lat > 0) ? 32'd1 : 32'd0);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: %0d results pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] res, input int lat);
    issue(name, op, a, b, res, lat, 1'b0);
    wait_done(name);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  bit saw_busy;
  bit saw_valid;

  initial begin
    rst = 1'b1; start = 1'b0; srcA = '0; srcB = '0; oper = MDU_MUL;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   {31'b0, busy},  32'd0);
    check("reset_valid",  {31'b0, valid}, 32'd0);
    check("reset_result", result,         32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("divu_100_7",   MDU_DIVU, 32'd100,        32'd7,          32'd14,         32);
    run("remu_100_7",   MDU_REMU, 32'd100,        32'd7,          32'd2,          32);
    run("div_m7_2",     MDU_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32);
    run("rem_m7_2",     MDU_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32);
    run("div_7_m2",     MDU_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32);
    run("rem_7_m2",     MDU_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          32);
    run("div_min_1",    MDU_DIV,  DIV_INT_MIN,    32'd1,          DIV_INT_MIN,    32);
    run("divu_5_0",     MDU_DIVU, 32'd5,          32'd0,          DIV_ALL_ONES,   0);
    run("rem_5_0",      MDU_REM,  32'd5,          32'd0,          32'd5,          0);
    run("rem_m7_0",     MDU_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  0);
    run("div_m7_0",     MDU_DIV,  32'hFFFF_FFF9,  32'd0,          DIV_ALL_ONES,   0);
    run("div_ovf",      MDU_DIV,  DIV_INT_MIN,    DIV_ALL_ONES,   DIV_INT_MIN,    0);
    run("rem_ovf",      MDU_REM,  DIV_INT_MIN,    DIV_ALL_ONES,   32'd0,          0);
    run("divu_ovf_ops", MDU_DIVU, DIV_INT_MIN,    DIV_ALL_ONES,   32'd0,          32);
    run("divu_max_min", MDU_DIVU, DIV_ALL_ONES,   DIV_INT_MIN,    32'd1,          32);

    // A second request while busy must be dropped.
    issue("ignored_in_calc", MDU_DIVU, 32'd100, 32'd7, 32'd14, 32, 1'b0);
    repeat (5) @(negedge clk);
    oper = MDU_DIVU; srcA = 32'd1000; srcB = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored_in_calc");

    // Multiply encodings are never accepted.
    saw_busy  = 1'b0;
    saw_valid = 1'b0;
    @(negedge clk);
    oper = MDU_MUL; srcA = 32'd9; srcB = 32'd3; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy)  saw_busy  = 1'b1;
      if (valid) saw_valid = 1'b1;
    end
    check("mul_not_accepted_busy",  {31'b0, saw_busy},  32'd0);
    check("mul_not_accepted_valid", {31'b0, saw_valid}, 32'd0);
    check("mul_result_held",        result,             32'd14);

    // Back-to-back: second request accepted on the edge ending the DONE cycle.
    issue("b2b_first", MDU_DIVU, 32'd100, 32'd7, 32'd14, 32, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (valid) break;
      @(negedge clk);
    end
    issue("b2b_second", MDU_REMU, 32'd100, 32'd7, 32'd2, 32, 1'b1);
    wait_done("b2b");

    // Reset in the middle of an iteration.
    issue("rst_mid", MDU_DIVU, DIV_ALL_ONES, 32'd3, 32'h5555_5555, 32, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    check("midrst_busy",   {31'b0, busy},  32'd0);
    check("midrst_valid",  {31'b0, valid}, 32'd0);
    check("midrst_result", result,         32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run("after_rst", MDU_DIVU, DIV_ALL_ONES, 32'd3, 32'h5555_5555, 32);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
